// File: rtl/clk_div_pkg.sv
`default_nettype none
// ==========================================================================
// clk_div_pkg : shared types and ratio constants for clk_div_prog. Rev 1.0
// ==========================================================================
package clk_div_pkg;

   typedef enum logic {
      MODE_SQUARE = 1'b0,
      MODE_TICK   = 1'b1
   } mode_e;

   localparam int DEF_CNT_W = 27;

   // Game of Life pacing ratios at a 50 MHz system clock
   localparam logic [DEF_CNT_W-1:0] GEN_DIV  = 27'd50_000_000;
   localparam logic [DEF_CNT_W-1:0] SCAN_DIV = 27'd50_000;

endpackage
`default_nettype wire

// File: rtl/clk_div_ch.sv
`default_nettype none
// ==========================================================================
// clk_div_ch : one programmable clock-enable divider channel. Rev 1.0
// ==========================================================================
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             sync_clr,
   input  logic             load,
   input  logic [CNT_W-1:0] div_in,
   input  logic             mode,
   output logic             q,
   output logic             tick
);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             tick_q, tick_d;

   logic [CNT_W-1:0] w_div_eff;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_last;
   logic             w_sq;

   // A stored ratio of zero behaves as divide-by-one
   assign w_div_eff = (div_q == '0) ? CNT_W'(1) : div_q;
   assign w_last    = (cnt_q == w_div_eff - CNT_W'(1));
   assign w_cnt_nxt = w_last ? '0 : cnt_q + CNT_W'(1);
   assign w_sq      = (w_cnt_nxt < (w_div_eff >> 1));

   always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      q_d    = q_q;
      tick_d = 1'b0;
      if (load) begin
         div_d = div_in;
         cnt_d = '0;
         q_d   = 1'b0;
      end else if (sync_clr) begin
         cnt_d = '0;
         q_d   = 1'b0;
      end else if (en) begin
         cnt_d  = w_cnt_nxt;
         tick_d = w_last;
         q_d    = (mode == MODE_TICK) ? w_last : w_sq;
      end else if (mode == MODE_TICK) begin
         q_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q  <= CNT_W'(DEFAULT_DIV);
         cnt_q  <= '0;
         q_q    <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         q_q    <= q_d;
         tick_q <= tick_d;
      end
   end

   assign q    = q_q;
   assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ==========================================================================
// clk_div_prog : multi-channel programmable clock-enable generator. Rev 1.0
// ==========================================================================
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              sync_clr,
   input  logic [NUM_CH-1:0] load,
   input  logic [CNT_W-1:0]  div_in,
   input  logic [NUM_CH-1:0] mode,
   output logic [NUM_CH-1:0] q,
   output logic [NUM_CH-1:0] tick
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .en       (en),
         .sync_clr (sync_clr),
         .load     (load[i]),
         .div_in   (div_in),
         .mode     (mode[i]),
         .q        (q[i]),
         .tick     (tick[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ==========================================================================
// tb_clk_div_prog : self-checking bench for clk_div_prog. Rev 1.0
// ==========================================================================
module tb_clk_div_prog;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 27;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic              sync_clr;
   logic [NUM_CH-1:0] load;
   logic [CNT_W-1:0]  div_in;
   logic [NUM_CH-1:0] mode;
   logic [NUM_CH-1:0] q;
   logic [NUM_CH-1:0] tick;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   // Reference: per channel, the ratio and the number of enabled edges
   // since the last restart, taken modulo the effective ratio.
   int m_div [NUM_CH];
   int m_ph  [NUM_CH];
   bit m_q   [NUM_CH];
   bit m_t   [NUM_CH];

   clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync_clr (sync_clr),
      .load     (load),
      .div_in   (div_in),
      .mode     (mode),
      .q        (q),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
         automatic int d  = (m_div[c] == 0) ? 1 : m_div[c];
         automatic int ph = m_ph[c];
         if (reset) begin
            m_div[c] <= 4;
            m_ph[c]  <= 0;
            m_q[c]   <= 1'b0;
            m_t[c]   <= 1'b0;
         end else if (load[c]) begin
            m_div[c] <= int'(div_in);
            m_ph[c]  <= 0;
            m_q[c]   <= 1'b0;
            m_t[c]   <= 1'b0;
         end else if (sync_clr) begin
            m_ph[c] <= 0;
            m_q[c]  <= 1'b0;
            m_t[c]  <= 1'b0;
         end else if (en) begin
            ph = (ph + 1) % d;
            m_ph[c] <= ph;
            m_t[c]  <= (ph == 0);
            m_q[c]  <= mode[c] ? (ph == 0) : (ph < d / 2);
         end else begin
            m_t[c] <= 1'b0;
            if (mode[c]) m_q[c] <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("model_q%0d", c), int'(q[c]), int'(m_q[c]));
            chk($sformatf("model_tick%0d", c), int'(tick[c]), int'(m_t[c]));
         end
      end
   end

   task automatic load_ch(input int c, input int val);
      load      = '0;
      load[c]   = 1'b1;
      div_in    = CNT_W'(val);
      @(negedge clk);
      load      = '0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; sync_clr = 1'b0;
      load = '0; div_in = '0; mode = '0;
      repeat (2) @(negedge clk);
      chk("reset_q", int'(q), 0);
      chk("reset_tick", int'(tick), 0);
      reset  = 1'b0;
      chk_on = 1'b1;

      // Default ratio 4, square mode
      en = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         chk("d4_q0", int'(q[0]), int'((e % 4) < 2));
         chk("d4_tick0", int'(tick[0]), int'(e % 4 == 0));
      end

      // Ratio 5 on channel 0: two high, three low
      load_ch(0, 5);
      chk("load5_q0", int'(q[0]), 0);
      for (int e = 1; e <= 10; e++) begin
         @(negedge clk);
         chk("d5_q0", int'(q[0]), int'((e % 5) < 2));
         chk("d5_tick0", int'(tick[0]), int'(e % 5 == 0));
      end

      // Tick mode, ratio 3 on channel 1, with a two-cycle pause
      mode = 2'b10;
      load_ch(1, 3);
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         chk("d3_tick1", int'(tick[1]), int'(e % 3 == 0));
         chk("d3_q1", int'(q[1]), int'(e % 3 == 0));
      end
      en = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("pause_tick1", int'(tick[1]), 0);
         chk("pause_q1", int'(q[1]), 0);
      end
      en = 1'b1;
      for (int e = 1; e <= 2; e++) begin
         @(negedge clk);
         chk("resume_tick1", int'(tick[1]), int'(e == 2));
      end

      // Ratio 0 and ratio 1 both divide by one
      load_ch(0, 0);
      load_ch(1, 1);
      repeat (4) begin
         @(negedge clk);
         chk("d1_tick", int'(tick), 3);
         chk("d1_q", int'(q), 2);
      end

      // Phase alignment via sync_clr with ratios 4 and 6
      mode = 2'b00;
      load_ch(0, 4);
      load_ch(1, 6);
      repeat ($urandom_range(3, 9)) @(negedge clk);
      sync_clr = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0;
      chk("sclr_tick", int'(tick), 0);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk("align_tick0", int'(tick[0]), int'(k % 4 == 0));
         chk("align_tick1", int'(tick[1]), int'(k % 6 == 0));
      end

      // Random traffic against the reference
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         en       = ($urandom_range(0, 9) != 0);
         sync_clr = ($urandom_range(0, 59) == 0);
         div_in   = CNT_W'($urandom_range(0, 9));
         for (int c = 0; c < NUM_CH; c++) load[c] = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 19) == 0) mode = NUM_CH'($urandom_range(0, 3));
      end
      @(negedge clk);
      load = '0; sync_clr = 1'b0; en = 1'b1;

      // Asynchronous reset between edges while ticks are high
      mode = 2'b01;
      load_ch(0, 5);
      load_ch(0, 1);
      repeat (2) @(negedge clk);
      chk("pre_rst_tick0", int'(tick[0]), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_q", int'(q), 0);
      chk("async_rst_tick", int'(tick), 0);
      @(negedge clk);
      mode  = 2'b00;
      reset = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         chk("post_rst_tick0", int'(tick[0]), int'(e == 4));
         chk("post_rst_q0", int'(q[0]), int'(e == 1 || e == 4));
      end

      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
